// File: rtl/vec_pkg.sv
// Shared defaults, the default vector type and the clear/run state encoding for vec_regfile.
// No logic lives here. Nothing in this file adds latency or backpressure.
package vec_pkg;
  localparam int DEF_LANES = 6;
  localparam int DEF_EW    = 8;
  localparam int DEF_NREGS = 10;
  localparam int DEF_AW    = 4;

  typedef logic [DEF_LANES-1:0][DEF_EW-1:0] vec_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;
endpackage

// File: rtl/vec_regfile_if.sv
// Interface for the vector register file: write/issue/clear requests in, read data and status out.
// Read data and busy flags return in the same cycle. There is no backpressure; ready is a status flag only.
interface vec_regfile_if
  import vec_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW,
  parameter int AW    = DEF_AW
) ();
  logic                       we;
  logic                       sflag;
  logic [LANES-1:0]           wmask;
  logic [AW-1:0]              a1;
  logic [AW-1:0]              a2;
  logic [AW-1:0]              a3;
  logic [LANES-1:0][EW-1:0]   wd;
  logic                       iss_v;
  logic [AW-1:0]              iss_reg;
  logic                       clr_req;
  logic [LANES-1:0][EW-1:0]   rd1;
  logic [LANES-1:0][EW-1:0]   rd2;
  logic                       busy1;
  logic                       busy2;
  logic                       ready;

  modport master (
    output we, sflag, wmask, a1, a2, a3, wd, iss_v, iss_reg, clr_req,
    input  rd1, rd2, busy1, busy2, ready
  );

  modport slave (
    input  we, sflag, wmask, a1, a2, a3, wd, iss_v, iss_reg, clr_req,
    output rd1, rd2, busy1, busy2, ready
  );
endinterface

// File: rtl/vec_lane_merge.sv
// Merges write data into an old vector: per-lane masked in vector mode, single lane a3 from wd[0] in scalar mode.
// Purely combinational, zero latency; it has no handshake and never stalls.
module vec_lane_merge #(
  parameter int LANES = 6,
  parameter int EW    = 8,
  parameter int AW    = 4
) (
  input  logic [LANES-1:0][EW-1:0] old_dat,
  input  logic [LANES-1:0][EW-1:0] wr_dat,
  input  logic [LANES-1:0]         wmask,
  input  logic                     sflag,
  input  logic [AW-1:0]            lane,
  output logic [LANES-1:0][EW-1:0] merged_dat
);
  always_comb begin
    merged_dat = old_dat;
    for (int i = 0; i < LANES; i++) begin
      if (sflag) begin
        if (32'(lane) == i) merged_dat[i] = wr_dat[0];
      end else if (wmask[i]) begin
        merged_dat[i] = wr_dat[i];
      end
    end
  end
endmodule

// File: rtl/vec_regfile.sv
// Vector register file: zeroing sweep after reset or clr_req, masked/scalar writes, optional bypass, pending bits.
// Reads and busy are combinational; writes land on the next edge. Requests are dropped while ready is low.
module vec_regfile
  import vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int EW     = DEF_EW,
  parameter int NREGS  = DEF_NREGS,
  parameter int AW     = DEF_AW,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  vec_regfile_if.slave  bus
);
  logic [LANES-1:0][EW-1:0] regs_q [NREGS];
  logic [LANES-1:0][EW-1:0] regs_d [NREGS];
  state_e                   state_q, state_d;
  logic [AW-1:0]            ptr_q, ptr_d;
  logic [NREGS-1:0]         pend_q, pend_d;

  logic                     run;
  logic                     wr_en;
  logic [AW-1:0]            wr_idx;
  logic [AW-1:0]            rd2_idx;
  logic [LANES-1:0][EW-1:0] wr_old, wr_new, rd1_raw, rd2_raw;
  logic                     busy1_raw, busy2_raw;

  // Scalar writes always target register 0; a3 then selects the lane.
  always_comb begin
    run     = (state_q == ST_RUN);
    wr_idx  = bus.sflag ? '0 : bus.a3;
    rd2_idx = bus.sflag ? '0 : bus.a2;
    wr_en   = run && bus.we &&
              (bus.sflag ? (32'(bus.a3) < LANES) : (32'(bus.a3) < NREGS));
  end

  always_comb begin
    wr_old    = '0;
    rd1_raw   = '0;
    rd2_raw   = '0;
    busy1_raw = 1'b0;
    busy2_raw = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (32'(wr_idx) == i) wr_old = regs_q[i];
      if (32'(bus.a1) == i) begin
        rd1_raw   = regs_q[i];
        busy1_raw = pend_q[i];
      end
      if (32'(rd2_idx) == i) begin
        rd2_raw   = regs_q[i];
        busy2_raw = pend_q[i];
      end
    end
  end

  vec_lane_merge #(
    .LANES (LANES),
    .EW    (EW),
    .AW    (AW)
  ) u_merge (
    .old_dat    (wr_old),
    .wr_dat     (bus.wd),
    .wmask      (bus.wmask),
    .sflag      (bus.sflag),
    .lane       (bus.a3),
    .merged_dat (wr_new)
  );

  // The merged write vector doubles as the forwarded read value.
  always_comb begin
    bus.rd1   = (BYPASS != 0 && wr_en && bus.a1 == wr_idx) ? wr_new : rd1_raw;
    bus.rd2   = (BYPASS != 0 && wr_en && rd2_idx == wr_idx) ? wr_new : rd2_raw;
    bus.busy1 = busy1_raw;
    bus.busy2 = busy2_raw;
    bus.ready = run;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (!run && 32'(ptr_q) == i) begin
        regs_d[i] = '0;
      end else if (wr_en && 32'(wr_idx) == i) begin
        regs_d[i] = wr_new;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    if (run) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en && 32'(wr_idx) == i) pend_d[i] = 1'b0;
        if (bus.iss_v && 32'(bus.iss_reg) == i) pend_d[i] = 1'b1;
      end
      if (bus.clr_req) begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        pend_d  = '0;
      end
    end else begin
      if (bus.clr_req) begin
        ptr_d = '0;
      end else if (32'(ptr_q) == NREGS - 1) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_vec_regfile.sv
// Directed bench for vec_regfile: clear sweep timing, masked/scalar writes, bypass, pending bits, reset restarts.
module tb_vec_regfile;
  localparam int LANES = 6;
  localparam int EW    = 8;
  localparam int NREGS = 10;
  localparam int AW    = 4;
  localparam logic [47:0] V6A = 48'h00_05_00_03_00_01;
  localparam logic [47:0] V6B = 48'hFF_05_00_03_00_01;
  localparam logic [47:0] R0A = 48'h00_00_00_AA_00_00;
  localparam logic [47:0] R0B = 48'h00_00_3C_AA_00_00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  vec_regfile_if #(.LANES(LANES), .EW(EW), .AW(AW)) bus ();

  vec_regfile #(
    .LANES (LANES), .EW (EW), .NREGS (NREGS), .AW (AW), .BYPASS (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chkv(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.we      = 1'b0;
    bus.sflag   = 1'b0;
    bus.wmask   = '0;
    bus.iss_v   = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  // ready must stay low for nine edges and rise exactly on the tenth
  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= NREGS; i++) begin
      tick();
      chkb(tag, bus.ready, i == NREGS);
    end
  endtask

  initial begin
    idle();
    bus.a1 = '0; bus.a2 = '0; bus.a3 = '0; bus.iss_reg = '0; bus.wd = '0;

    #12;
    chkb("rst_ready", bus.ready, 1'b0);
    chkb("rst_busy1", bus.busy1, 1'b0);
    chkb("rst_busy2", bus.busy2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    sweep_wait("init_sweep_ready");

    for (int r = 0; r < NREGS; r++) begin
      bus.a1 = AW'(r);
      bus.a2 = AW'(NREGS - 1 - r);
      settle();
      chkv("init_rd1_zero", bus.rd1, '0);
      chkv("init_rd2_zero", bus.rd2, '0);
    end
    bus.a1 = 4'd15;
    settle();
    chkv("oob_read_zero", bus.rd1, '0);

    // masked vector write with same-cycle forwarding
    bus.a1 = 4'd6; bus.a2 = 4'd6; bus.a3 = 4'd6;
    bus.we = 1'b1; bus.wmask = 6'b010101; bus.wd = 48'h06_05_04_03_02_01;
    settle();
    chkv("vw_bypass_rd1", bus.rd1, V6A);
    chkv("vw_bypass_rd2", bus.rd2, V6A);
    tick();
    bus.we = 1'b0;
    settle();
    chkv("vw_stored", bus.rd1, V6A);
    bus.a1 = 4'd5;
    settle();
    chkv("vw_neighbor", bus.rd1, '0);
    bus.a1 = 4'd6;
    bus.we = 1'b1; bus.wmask = 6'b100000; bus.wd = 48'hFF_EE_DD_CC_BB_AA;
    tick();
    bus.we = 1'b0;
    settle();
    chkv("vw_keep_lanes", bus.rd1, V6B);

    // scalar write ignores wmask and reads rd2 from register 0
    bus.sflag = 1'b1; bus.a3 = 4'd2; bus.a1 = 4'd0; bus.a2 = 4'd6;
    bus.wmask = 6'h3F; bus.wd = 48'h11_22_33_44_55_AA; bus.we = 1'b1;
    settle();
    chkv("sw_bypass_rd2", bus.rd2, R0A);
    tick();
    bus.we = 1'b0;
    settle();
    chkv("sw_rd2_reg0", bus.rd2, R0A);
    bus.a1 = 4'd6;
    settle();
    chkv("sw_vec_untouched", bus.rd1, V6B);
    bus.a3 = 4'd7; bus.wd = 48'h77; bus.we = 1'b1;
    tick();
    bus.we = 1'b0; bus.a1 = 4'd7;
    settle();
    chkv("sw_oob_reg0", bus.rd2, R0A);
    chkv("sw_oob_reg7", bus.rd1, '0);
    bus.sflag = 1'b0; bus.a3 = 4'd12; bus.wmask = 6'h3F;
    bus.wd = 48'h77_77_77_77_77_77; bus.we = 1'b1;
    tick();
    bus.we = 1'b0; bus.a1 = 4'd12;
    settle();
    chkv("vw_oob_rd", bus.rd1, '0);
    bus.a1 = 4'd6;
    settle();
    chkv("vw_oob_reg6", bus.rd1, V6B);

    // pending bits: set, set-wins, clear by vector and scalar writes
    bus.iss_v = 1'b1; bus.iss_reg = 4'd7;
    tick();
    bus.iss_v = 1'b0; bus.a1 = 4'd7; bus.a2 = 4'd7;
    settle();
    chkb("pend_busy1", bus.busy1, 1'b1);
    chkb("pend_busy2", bus.busy2, 1'b1);
    bus.we = 1'b1; bus.a3 = 4'd7; bus.wmask = '0; bus.iss_v = 1'b1;
    tick();
    bus.we = 1'b0; bus.iss_v = 1'b0;
    settle();
    chkb("pend_set_wins", bus.busy1, 1'b1);
    bus.we = 1'b1; bus.wmask = 6'b000001; bus.wd = 48'h5A;
    tick();
    bus.we = 1'b0;
    settle();
    chkb("pend_vw_clear", bus.busy1, 1'b0);
    chkv("pend_vw_data", bus.rd1, 48'h5A);
    bus.iss_v = 1'b1; bus.iss_reg = 4'd0;
    tick();
    bus.iss_v = 1'b0; bus.sflag = 1'b1;
    settle();
    chkb("busy2_scalar_bit0", bus.busy2, 1'b1);
    chkb("busy1_reg7_clear", bus.busy1, 1'b0);
    bus.we = 1'b1; bus.a3 = 4'd3; bus.wd = 48'h3C;
    tick();
    bus.we = 1'b0;
    settle();
    chkb("busy2_sw_clear", bus.busy2, 1'b0);
    chkv("sw_lane3", bus.rd2, R0B);
    bus.sflag = 1'b0;

    // clr_req from RUN: pending cleared, CLEAR-time writes and issues dropped
    bus.iss_v = 1'b1; bus.iss_reg = 4'd5;
    tick();
    bus.iss_v = 1'b0; bus.a1 = 4'd5;
    settle();
    chkb("clr_pre_busy", bus.busy1, 1'b1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    settle();
    chkb("clr_ready_low", bus.ready, 1'b0);
    chkb("clr_pend_cleared", bus.busy1, 1'b0);
    bus.we = 1'b1; bus.a3 = 4'd1; bus.wmask = 6'h3F; bus.wd = 48'h99_99_99_99_99_99;
    bus.iss_v = 1'b1; bus.iss_reg = 4'd4;
    sweep_wait("clr_sweep_ready");
    idle();
    bus.a1 = 4'd1;
    settle();
    chkv("clr_write_lost", bus.rd1, '0);
    bus.a1 = 4'd4;
    settle();
    chkb("clr_issue_lost", bus.busy1, 1'b0);
    bus.a1 = 4'd6; bus.sflag = 1'b1;
    settle();
    chkv("clr_reg6_zero", bus.rd1, '0);
    chkv("clr_reg0_zero", bus.rd2, '0);
    bus.sflag = 1'b0;

    // rst in RUN, then again at sweep cycle 4
    bus.we = 1'b1; bus.a3 = 4'd3; bus.wmask = 6'h3F; bus.wd = 48'h01_02_03_04_05_06;
    bus.iss_v = 1'b1; bus.iss_reg = 4'd3;
    tick();
    idle();
    bus.a1 = 4'd3;
    settle();
    chkv("rst_pre_data", bus.rd1, 48'h01_02_03_04_05_06);
    chkb("rst_pre_busy", bus.busy1, 1'b1);
    rst = 1'b1;
    settle();
    chkb("rst_async_busy", bus.busy1, 1'b0);
    chkb("rst_async_ready", bus.ready, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chkb("rst_mid_ready", bus.ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_wait("rst_sweep_ready");
    settle();
    chkv("rst_reg3_zero", bus.rd1, '0);
    chkb("rst_busy_zero", bus.busy1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vec_regfile.md
VEC_REGFILE -- requirements
Module: vec_regfile

Interface
Parameters:
REQ-001 SHALL have parameter LANES, default 6: elements per vector.
REQ-002 SHALL have parameter EW, default 8: element width in bits.
REQ-003 SHALL have parameter NREGS, default 10: vector register count; register 0 holds the LANES scalar registers.
REQ-004 SHALL have parameter AW, default 4: register index width; NREGS <= 2**AW.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding.

Ports:
REQ-006 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port we, input, 1: write enable.
REQ-009 SHALL have port sflag, input, 1: scalar mode.
REQ-010 SHALL have port wmask, input, LANES: per-lane write enable, vector mode only.
REQ-011 SHALL have ports a1, a2, a3, input, AW each: read indices a1/a2, write index a3.
REQ-012 SHALL have port wd, input, LANES x EW: write data.
REQ-013 SHALL have port iss_v, input, 1: issue marks iss_reg pending.
REQ-014 SHALL have port iss_reg, input, AW: register being issued.
REQ-015 SHALL have port clr_req, input, 1: starts a re-clear sweep.
REQ-016 SHALL have ports rd1, rd2, output, LANES x EW: read vectors.
REQ-017 SHALL have ports busy1, busy2, output, 1: pending bit of a1 / a2.
REQ-018 SHALL have port ready, output, 1: high when state is RUN.

Function
REQ-019 SHALL implement FSM states CLEAR and RUN.
REQ-020 In CLEAR, SHALL write zero to register ptr each cycle, ptr counting 0..NREGS-1, then enter RUN; sweep takes NREGS cycles.
REQ-021 SHALL have ready = 0 in CLEAR; we and iss_v SHALL be ignored in CLEAR.
REQ-022 In RUN, clr_req SHALL enter CLEAR with ptr = 0 and clear all pending bits; clr_req in CLEAR SHALL restart ptr at 0.
REQ-023 Vector write (we, !sflag, a3 < NREGS): lanes with wmask[i] = 1 SHALL take wd[i]; other lanes keep their value.
REQ-024 Scalar write (we, sflag, a3 < LANES): register 0 lane a3 SHALL take wd[0]; wmask SHALL be ignored.
REQ-025 Writes with an out-of-range a3 SHALL be discarded.
REQ-026 rd1 SHALL be register a1, combinational.
REQ-027 rd2 SHALL be register 0 when sflag = 1, else register a2.
REQ-028 Out-of-range read indices SHALL return zero.
REQ-029 With BYPASS = 1 and a same-cycle RUN write hitting the read register, rd SHALL show the post-write merged value.
REQ-030 With BYPASS = 0, reads SHALL show the pre-edge value.
REQ-031 Pending: iss_v sets bit iss_reg; a vector write, or a scalar write (clears bit 0), clears bit a3.
REQ-032 Set and clear of the same bit in one cycle SHALL leave it set (set wins).
REQ-033 busy1/busy2 SHALL be combinational lookups of the pending bits; scalar-mode busy2 SHALL report bit 0.

Reset
REQ-034 rst SHALL asynchronously force state = CLEAR, ptr = 0, all pending bits 0, ready = 0.
REQ-035 The register array SHALL have no reset and SHALL be zeroed only by the sweep; rst mid-sweep SHALL restart the sweep at 0.
REQ-036 rd1/rd2 SHALL be undefined until the first sweep completes; busy1/busy2 SHALL be 0 during reset.

Structure
REQ-037 Package vec_pkg SHALL hold the defaults LANES/EW/NREGS/AW, typedef vec_t (LANES x EW) and the state enum.
REQ-038 SHALL contain one sub-module, vec_lane_merge (mask/scalar merge of old and write data), shared by the write path and the bypass.

Verification
REQ-039 Release rst; ready SHALL rise after exactly 10 cycles; all reads SHALL return 0.
REQ-040 Vector write a3 = 6, wd = 06..01, wmask = 6'b010101 SHALL update only lanes 0, 2, 4; same-cycle a1 = 6 SHALL show the merged value (BYPASS = 1).
REQ-041 Scalar write sflag = 1, a3 = 2, wd[0] = 8'hAA SHALL set only register 0 lane 2; rd2 SHALL return register 0; a3 = 7 SHALL be discarded.
REQ-042 iss_v with iss_reg = 7, then a same-cycle write a3 = 7 and iss_v for 7: busy1 (a1 = 7) SHALL stay 1; a later write SHALL clear it.
REQ-043 Assert rst at sweep cycle 4 and clr_req in RUN; each SHALL restart a full 10-cycle sweep and clear pending bits; writes during CLEAR SHALL be lost.
